// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and the UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                   enable;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     lock;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     ack;
  logic                   txrdy;
  logic [7:0]             tx_hold_reg;
  logic                   rst_tx_empty;
  logic [NUM_REQ-1:0]     grant;
  logic                   busy;
  logic                   timeout_err;
  logic                   err_clr;

  // Requester / transmitter side.
  modport master (
    output enable, req, lock, req_data, txrdy, err_clr,
    input  ack, tx_hold_reg, rst_tx_empty, grant, busy, timeout_err
  );

  // Arbiter side.
  modport slave (
    input  enable, req, lock, req_data, txrdy, err_clr,
    output ack, tx_hold_reg, rst_tx_empty, grant, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto one UART transmit holding register.
// Round-robin with optional burst locking, plus a watchdog on the transmitter
// taking the byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, WAIT_TAKEN} state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic               owner_vld;
  logic [3:0]         burst_cnt;
  logic [7:0]         wait_cnt;

  logic               keep;
  logic               rr_hit;
  logic [IW-1:0]      rr_win;
  logic [IW-1:0]      win;
  logic [IW-1:0]      win_next;
  logic [NUM_REQ-1:0] win_oh;
  logic               grant_ok;

  // Winner selection: sticky owner while its burst is allowed, else first
  // request at or above rr_ptr with wrap.
  always_comb begin
    rr_hit = 1'b0;
    rr_win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rr_hit && bus.req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        rr_hit = 1'b1;
        rr_win = IW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
    keep     = owner_vld && bus.lock[owner] && bus.req[owner] &&
               (burst_cnt < 4'(MAX_BURST));
    win      = keep ? owner : rr_win;
    win_next = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    win_oh   = '0;
    win_oh[win] = 1'b1;
    grant_ok = bus.enable && bus.txrdy && (|bus.req);
  end

  // Two-state transfer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bus.tx_hold_reg  <= 8'h00;
      bus.rst_tx_empty <= 1'b0;
      bus.ack          <= '0;
      bus.grant        <= '0;
      bus.busy         <= 1'b0;
      bus.timeout_err  <= 1'b0;
      rr_ptr           <= '0;
      owner            <= '0;
      owner_vld        <= 1'b0;
      burst_cnt        <= '0;
      wait_cnt         <= '0;
    end else begin
      bus.ack          <= '0;
      bus.rst_tx_empty <= 1'b0;
      // Clear first so a same-cycle timeout below overrides it.
      if (bus.err_clr) bus.timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (grant_ok) begin
          bus.tx_hold_reg  <= bus.req_data[int'(win)*8 +: 8];
          bus.ack          <= win_oh;
          bus.rst_tx_empty <= 1'b1;
          bus.grant        <= win_oh;
          bus.busy         <= 1'b1;
          state            <= WAIT_TAKEN;
          burst_cnt        <= keep ? burst_cnt + 4'd1 : 4'd1;
          rr_ptr           <= win_next;
          owner            <= win;
          owner_vld        <= 1'b1;
          wait_cnt         <= '0;
        end
      end else begin
        if (!bus.txrdy) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          wait_cnt <= '0;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          // Transmitter never took the byte: flag it and give up, no retry.
          bus.timeout_err <= 1'b1;
          state           <= IDLE;
          bus.busy        <= 1'b0;
          wait_cnt        <= '0;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of grants plus hand
// sequences for timeout, reset mid-transfer and enable gating.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] lock;
    int           idx;
  } vec_t;

  vec_t       tbl [14];
  logic [7:0] bytes [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for an ack pulse, sampling 1 time unit after each edge.
  task automatic wait_ack(input string name, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.ack != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  // One full transfer: grant, one-cycle strobe, transmitter takes the byte.
  task automatic xfer(input string name, input int idx);
    bit got;
    wait_ack(name, got);
    if (got) begin
      chk({name, "_ack"},   32'(bus.ack),          32'(1 << idx));
      chk({name, "_grant"}, 32'(bus.grant),        32'(1 << idx));
      chk({name, "_data"},  32'(bus.tx_hold_reg),  32'(bytes[idx]));
      chk({name, "_strb"},  32'(bus.rst_tx_empty), 32'd1);
      chk({name, "_busy"},  32'(bus.busy),         32'd1);
      @(posedge clk); #1;
      chk({name, "_ack_once"}, 32'(bus.ack),  32'd0);
      chk({name, "_busy2"},    32'(bus.busy), 32'd1);
      bus.txrdy = 1'b0;
      @(posedge clk); #1;
      chk({name, "_idle"}, 32'(bus.busy), 32'd0);
      bus.txrdy = 1'b1;
    end
  endtask

  // Grants must never land on adjacent cycles; strobe tracks ack.
  logic [N-1:0] prev_ack = '0;
  always @(negedge clk) begin
    if (!reset && bus.ack != '0) begin
      chk("ack_gap", 32'(prev_ack), 32'd0);
      chk("strobe_vs_ack", 32'(bus.rst_tx_empty), 32'd1);
    end
    prev_ack <= bus.ack;
  end

  initial begin
    bit got;
    int n;
    bit seen;

    bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[2] = 8'hA5; bytes[3] = 8'h43;
    // rr_ptr starts at 0: plain round-robin, then single request, then burst.
    tbl[0]  = '{4'b1111, 4'b0000, 0};
    tbl[1]  = '{4'b1111, 4'b0000, 1};
    tbl[2]  = '{4'b1111, 4'b0000, 2};
    tbl[3]  = '{4'b1111, 4'b0000, 3};
    tbl[4]  = '{4'b1111, 4'b0000, 0};
    tbl[5]  = '{4'b0100, 4'b0000, 2};
    tbl[6]  = '{4'b0001, 4'b0000, 0};  // leaves rr_ptr=1
    tbl[7]  = '{4'b0011, 4'b0010, 1};
    tbl[8]  = '{4'b0011, 4'b0010, 1};
    tbl[9]  = '{4'b0011, 4'b0010, 1};
    tbl[10] = '{4'b0011, 4'b0010, 1};  // burst_cnt now 4
    tbl[11] = '{4'b0011, 4'b0010, 0};  // saturated owner loses to rr
    tbl[12] = '{4'b0011, 4'b0010, 1};  // rr gives it back, burst_cnt=1
    tbl[13] = '{4'b1001, 4'b0010, 3};  // owner dropped req: forfeits burst

    bus.enable   = 1'b1;
    bus.req      = '0;
    bus.lock     = '0;
    bus.req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    bus.txrdy    = 1'b1;
    bus.err_clr  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {bus.tx_hold_reg, bus.ack, bus.grant, bus.rst_tx_empty,
                       bus.busy, bus.timeout_err}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 14; v++) begin
      bus.req  = tbl[v].req;
      bus.lock = tbl[v].lock;
      xfer($sformatf("vec%0d", v), tbl[v].idx);
    end

    // Timeout: txrdy stays 1 after grant.
    bus.lock = '0;
    bus.req  = 4'b0001;
    wait_ack("to", got);
    chk("to_ack", 32'(bus.ack), 32'd1);
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.timeout_err) begin n = i; break; end
    end
    chk("to_cycles", 32'(n), 32'd15);
    chk("to_idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("to_regrant", 32'(bus.ack), 32'd1);
    // Hold err_clr through a second timeout: clear works, set wins on collision.
    bus.req     = '0;
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    chk("err_clr", 32'(bus.timeout_err), 32'd0);
    n = 41;
    for (int i = 2; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.timeout_err) begin n = i; break; end
    end
    chk("set_wins", 32'(n), 32'd15);
    @(posedge clk); #1;
    chk("err_clr2", 32'(bus.timeout_err), 32'd0);
    bus.err_clr = 1'b0;

    // Reset during WAIT_TAKEN.
    bus.req = 4'b1111;
    wait_ack("rst", got);
    @(posedge clk); #1;
    #3 reset = 1'b1;
    #1;
    chk("rst_async", {bus.tx_hold_reg, bus.ack, bus.grant, bus.rst_tx_empty,
                      bus.busy, bus.timeout_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_first_grant", 32'(bus.ack), 32'd1);
    @(posedge clk); #1;
    bus.txrdy = 1'b0;
    @(posedge clk); #1;
    bus.txrdy = 1'b1;
    bus.req   = '0;

    // Enable gating.
    bus.enable = 1'b0;
    bus.req    = 4'b0001;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.ack != '0) seen = 1'b1;
    end
    chk("en_blocked", 32'(seen), 32'd0);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    chk("en_grant", 32'(bus.ack), 32'd1);
    bus.req = '0;
    @(posedge clk); #1;
    bus.txrdy = 1'b0;
    @(posedge clk); #1;
    bus.txrdy = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters, legal range 2..8.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive locked grants to one requester, legal range 1..15.
REQ-003 Parameter TIMEOUT, default 15: cycles to wait for the transmitter to take a byte, legal range 2..255.
REQ-004 Clock and reset SHALL be a single clock `clk` and a reset `reset` that is asynchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: 0 blocks new grants; an in-flight transfer still completes.
- req, in, NUM_REQ: per-requester byte request, held high until ack.
- lock, in, NUM_REQ: per-requester burst-hold request.
- req_data, in, 8*NUM_REQ: byte of requester i on bits [8i+7:8i], stable while req[i]=1.
- ack, out, NUM_REQ: one-cycle, one-hot pulse; the byte was loaded.
- txrdy, in, 1: transmitter holding register empty (1 = free).
- tx_hold_reg, out, 8: byte presented to the transmitter.
- rst_tx_empty, out, 1: one-cycle load strobe to the transmitter.
- grant, out, NUM_REQ: one-hot owner of the current or last transfer.
- busy, out, 1: high whenever the state is not IDLE.
- timeout_err, out, 1: sticky error flag.
- err_clr, in, 1: clears timeout_err.

Function
REQ-006 The FSM SHALL have exactly two states: IDLE and WAIT_TAKEN.
REQ-007 IDLE SHALL issue a grant at a clock edge only when enable=1, txrdy=1 and req is non-zero; otherwise it SHALL stay in IDLE with all outputs held.
REQ-008 On a grant to requester w, the following SHALL be registered at that edge:
- tx_hold_reg <= req_data[w];
- rst_tx_empty <= 1 and ack[w] <= 1, each for exactly one cycle;
- grant <= onehot(w);
- state <= WAIT_TAKEN.
REQ-009 Winner selection SHALL keep the previous owner p when all of the following hold:
- p is valid;
- lock[p]=1 and req[p]=1;
- burst_cnt < MAX_BURST.
In that case w=p and burst_cnt SHALL increment by 1.
REQ-010 Otherwise w SHALL be the first set req bit searching upward from rr_ptr with wrap from NUM_REQ-1 to 0, and burst_cnt SHALL be set to 1.
REQ-011 After every grant, rr_ptr SHALL be set to (w+1) mod NUM_REQ, and p SHALL be set to w and marked valid.
REQ-012 burst_cnt SHALL be 4 bits wide and SHALL saturate at MAX_BURST; a saturated owner SHALL lose priority to round-robin, and is re-eligible through round-robin only.
REQ-013 WAIT_TAKEN SHALL return to IDLE on the first cycle with txrdy=0, and SHALL clear wait_cnt.
REQ-014 wait_cnt SHALL increment on each WAIT_TAKEN cycle with txrdy=1.
REQ-015 When wait_cnt reaches TIMEOUT, the block SHALL set timeout_err=1, return to IDLE and clear wait_cnt; no retry is made and the ack already given stands.
REQ-016 The req and lock inputs SHALL be ignored while in WAIT_TAKEN; a requester deasserting req there has no effect.
REQ-017 Successive grants SHALL be at least 2 cycles apart; ack and rst_tx_empty SHALL never be high on adjacent cycles.
REQ-018 Dropping enable SHALL NOT abort WAIT_TAKEN, and SHALL NOT reset rr_ptr, p or burst_cnt.
REQ-019 err_clr=1 SHALL clear timeout_err at the next edge; when err_clr and a timeout occur on the same cycle, the set wins.
REQ-020 An owner p whose req[p]=0 in IDLE SHALL forfeit the burst; the next grant then uses round-robin.

Reset
REQ-021 While reset=1, the block SHALL immediately set:
- state=IDLE;
- tx_hold_reg=8'h00;
- rst_tx_empty=0, ack=0, grant=0, busy=0, timeout_err=0;
- rr_ptr=0, burst_cnt=0, wait_cnt=0, p invalid.
REQ-022 A reset asserted mid-transfer SHALL discard the transfer without issuing an ack, and the first grant after reset release SHALL be evaluated on the first clock edge with reset=0.

Verification
REQ-023 Single request: req=4'b0100 with data 8'hA5, txrdy=1, txrdy forced to 0 one cycle after rst_tx_empty -> tx_hold_reg=A5, ack=4'b0100 pulses once, busy high for 2 cycles.
REQ-024 Round-robin: req=4'b1111 held, lock=0, txrdy toggling normally -> grant order 0,1,2,3,0; each requester is acked once per 4 grants.
REQ-025 Burst: lock[1]=1, req=4'b0011 held, MAX_BURST=4 -> grants 1,1,1,1,0 (after rr_ptr=1 start); burst_cnt saturates at 4.
REQ-026 Timeout: txrdy stuck at 1 after a grant -> timeout_err rises after 15 WAIT_TAKEN cycles, the FSM returns to IDLE and re-grants; err_clr then clears the flag.
REQ-027 Reset mid-transfer: assert reset during WAIT_TAKEN -> all outputs are 0 asynchronously (before the next edge) and the next grant after release goes to requester 0 when req=4'b1111.
REQ-028 Enable gating: enable=0 with req=4'b0001 -> no ack for 20 cycles; setting enable=1 -> ack[0] pulses within 1 cycle.
